// File: rtl/pw_periph_pkg.sv
// Shared definitions for Picowizard bus peripherals: register offsets,
// STATUS bit layout, TX state encoding and a count saturation helper.
package pw_periph_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV_LO = 2'd2;
  localparam logic [1:0] UART_DIV_HI = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // FIFO occupancy squeezed into the 4-bit STATUS field.
  function automatic logic [3:0] sat_count(input logic [8:0] c);
    return (c > 9'd15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (int'(count) == DEPTH);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go through a TX FIFO into
// a shift-out FSM; STATUS/DIV are readable with one-cycle registered latency.
module uart_tx_peripheral
  import pw_periph_pkg::*;
#(
  parameter logic [15:0] BASE_ADR    = 16'hFFF0,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd1475
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [15:0] AdrIn,
  input  logic [7:0]  DataIn,
  input  logic        WrtMem,
  input  logic        LdMem,
  output logic [7:0]  DataOut,
  output logic        Hit,
  output logic        TxD,
  output logic        TxBusy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   off;
  logic [1:0]    sel;
  logic          wr;
  logic          rd;
  logic          data_wr;
  logic          ovf_set;
  logic          ovf;
  logic [15:0]   div;
  logic [7:0]    status;
  logic [7:0]    rd_data;

  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [15:0]   cnt;
  logic [15:0]   cnt_nxt;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          txd_nxt;
  logic          pop;

  assign off     = AdrIn - BASE_ADR;
  assign sel     = off[1:0];
  assign Hit     = (off < 16'd4);
  assign wr      = WrtMem && Hit;
  assign rd      = LdMem && Hit;
  assign data_wr = wr && (sel == UART_DATA);
  assign ovf_set = data_wr && fifo_full && !pop;
  assign TxBusy  = (state != TX_IDLE) || !fifo_empty;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (ResetN),
    .push  (data_wr),
    .wdata (DataIn),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble STATUS and select the register being read.
  always_comb begin
    status                         = '0;
    status[STAT_BUSY]              = TxBusy;
    status[STAT_FULL]              = fifo_full;
    status[STAT_EMPTY]             = fifo_empty;
    status[STAT_OVF]               = ovf;
    status[STAT_CNT_LSB +: 4]      = sat_count(9'(fifo_count));
    rd_data                        = '0;
    case (sel)
      UART_STATUS: rd_data = status;
      UART_DIV_LO: rd_data = div[7:0];
      UART_DIV_HI: rd_data = div[15:8];
      default:     rd_data = '0;
    endcase
  end

  // Bus-side registers: read data, sticky overflow (set beats clear), divider.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      DataOut <= '0;
      ovf     <= 1'b0;
      div     <= DEFAULT_DIV;
    end else begin
      if (rd) DataOut <= rd_data;
      if (ovf_set)                          ovf <= 1'b1;
      else if (rd && sel == UART_STATUS)    ovf <= 1'b0;
      if (wr && sel == UART_DIV_LO) div[7:0]  <= DataIn;
      if (wr && sel == UART_DIV_HI) div[15:8] <= DataIn;
    end
  end

  // Next-state logic; baud counter reloads from the live divider at every bit boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_rdata;
          cnt_nxt   = div;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (cnt == '0) begin
          cnt_nxt   = div;
          idx_nxt   = '0;
          state_nxt = TX_DATA;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt == '0) begin
          cnt_nxt = div;
          if (idx == 3'd7) begin
            state_nxt = TX_STOP;
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            idx_nxt   = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_rdata;
            cnt_nxt   = div;
            state_nxt = TX_START;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
    case (state_nxt)
      TX_START: txd_nxt = 1'b0;
      TX_DATA:  txd_nxt = shift_nxt[0];
      default:  txd_nxt = 1'b1;
    endcase
  end

  // FSM control registers; TxD is registered from the next state so the line never glitches.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      TxD   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      TxD   <= txd_nxt;
    end
  end

  // Shift data register carries no reset; it is only observed after a load.
  always_ff @(posedge Clk) begin
    shift <= shift_nxt;
  end

endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter on the Picowizard CPU bus, beside the BIOS memory and VGA driver and driven by the same CPU address, data and strobe nets. The CPU writes bytes into a small FIFO. A shift-out state machine serialises them as 8N1 frames on `TxD` at a programmable bit rate. Status and divider registers are readable with the same one-cycle read latency as the block RAM, so the top-level read mux treats this block like memory.

## Interface
- `BASE_ADR`, 16'hFFF0: base of the 4-byte register window. The top-level decode must route reads at `BASE_ADR..BASE_ADR+3` to `DataOut`.
- `FIFO_DEPTH`, 16: TX FIFO entries. Must be a power of two, 2..256.
- `DEFAULT_DIV`, 16'd1475: divider reset value. Bit period = DIV+1 cycles, which gives 115200 baud at 170 MHz.

Ports:
- `Clk`  in  1  CPU main clock.
- `ResetN`  in  1  reset, asynchronous, active-low.
- `AdrIn`  in  16  CPU address.
- `DataIn`  in  8  CPU write data.
- `WrtMem`  in  1  CPU write strobe, one cycle per access.
- `LdMem`  in  1  CPU read strobe, one cycle per access.
- `DataOut`  out  8  registered read data.
- `Hit`  out  1  combinational: `AdrIn` is inside the window.
- `TxD`  out  1  serial output, idle high.
- `TxBusy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Register map, as offsets from `BASE_ADR`:
  - +0 DATA. A write pushes a byte into the FIFO. A read returns 0.
  - +1 STATUS, read-only:
    - bit0 busy
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] FIFO count, saturating at 15
  - +2 DIV_LO and +3 DIV_HI, read/write.
- Reading STATUS clears overflow. If a push overflows in the same cycle as the STATUS read, overflow is set and not cleared.
- FIFO push rules:
  - A DATA write is accepted if the FIFO is not full, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Count is unchanged when a push and a pop occur in the same cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, load the baud counter with DIV, go to START.
  - START: `TxD`=0 until the baud counter reaches 0, then go to DATA with bit index 0.
  - DATA: `TxD`=shift[0], sent LSB first. At the end of each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `TxD`=1 for one bit period. At its end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter:
  - 16-bit down-counter, reloaded with the current DIV at every bit boundary.
  - A DIV write mid-frame takes effect at the next bit boundary.
  - DIV=0 gives one cycle per bit.
- Reset values:
  - `TxD`=1, `DataOut`=0, `TxBusy`=0.
  - FIFO empty, overflow=0, DIV=`DEFAULT_DIV`, state IDLE.
  - A reset mid-frame forces `TxD` high immediately (asynchronously) and discards the frame and the FIFO contents.

## Timing
- Read latency is 1 cycle:
  - With `LdMem` and `Hit` high at edge t, `DataOut` is valid from t until the next read.
  - `DataOut` holds its value when there is no read.
- Writes take effect at the sampling edge.
- Start-of-frame latency: a DATA write at edge t0 into an empty FIFO with the FSM in IDLE makes `TxD` fall at edge t0+1.
- Frame length is exactly 10·(DIV+1) cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `TxBusy` drops at the edge where STOP ends with the FIFO empty.
- `TxD` is a registered output and is glitch-free.

## Structure
- Package `pw_periph_pkg` holds:
  - register offsets (`UART_DATA`, `UART_STATUS`, `UART_DIV_LO`, `UART_DIV_HI`)
  - STATUS bit positions
  - the `tx_state_t` enum
- Sub-module `sync_fifo`, parameterised by width and depth:
  - outputs: push/pop, full/empty, count
  - single clock, same `ResetN`
  - reusable for a later RX path

## Test plan
- Reset: hold `ResetN`=0 → `TxD`=1, `DataOut`=0. Then read STATUS → 8'h04, and read DIV → 1475 (DIV_LO 8'hC3, DIV_HI 8'h05).
- Single byte: set DIV=3, write 8'hA5 to DATA → `TxD` falls 1 cycle later. Bits follow LSB first (0,1,0,1,0,0,1,0,1 then stop 1), 4 cycles each, 40 cycles total, then `TxBusy`=0.
- Back-to-back: with DIV=0, write 8'h01, 8'h02, 8'h03 on consecutive cycles → 30 contiguous bit cycles with no idle gap between frames.
- Overflow: with DIV large, write 18 bytes → the first is in flight and 16 are queued. STATUS reads full=1 and overflow=1; a second STATUS read shows overflow=0.
- DIV change mid-frame: start a frame at DIV=7, write DIV_LO=1 during bit 2 → the current bit keeps 8 cycles and later bits are 2 cycles each.
- Reset mid-frame: assert `ResetN` during bit 4 with 3 bytes queued → `TxD`=1 asynchronously. After release, STATUS = 8'h04 and no further frames are sent.
